// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_pkg
//  Purpose  : Shared types and helpers for the switch debounce block.
//             - dbnc_state_e : debounce FSM state encoding
//             - cnt_width()  : width of the stability counter
//  Revision : 1.0  initial release
// ============================================================================
package debounce_pkg;

  // STABLE_* states hold a settled level.
  // PEND_* states are qualifying a candidate level.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    PEND_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    PEND_LOW    = 2'd3
  } dbnc_state_e;

  // The counter only has to reach cycles-1, so $clog2(cycles) bits are enough.
  // Clamped to 1 so that a degenerate parameter still yields a legal vector.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Generic two-flop synchroniser for asynchronous pad inputs.
//             Reset clears both stages to 0.
//  Ports    : clk    - destination clock
//             rst    - synchronous, active-high reset
//             d_async- asynchronous input (WIDTH bits, each bit independent)
//             q_sync - synchronised output, two clk edges of latency
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_async,
  output logic [WIDTH-1:0] q_sync
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // The first stage may go metastable; only the second stage is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_async;
      sync_q <= meta_q;
    end
  end

  assign q_sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : switch_debounce
//  Purpose  : Synchronises a raw bouncing switch into the clk domain, then
//             accepts a new level only after DEBOUNCE_CYCLES consecutive
//             stable samples. Produces the clean level, one-cycle rise/fall
//             strobes and a wrapping count of accepted presses.
//  Ports    : clk         - system clock
//             rst         - synchronous, active-high reset
//             d_raw       - raw asynchronous switch/button pad
//             d_clean     - debounced level (feeds the downstream latch d)
//             rise        - one-cycle pulse when d_clean goes 0->1
//             fall        - one-cycle pulse when d_clean goes 1->0
//             press_count - accepted rising edges, wraps modulo 2^CNT_W
//  Revision : 1.0  initial release
// ============================================================================
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_raw,
  output logic             d_clean,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] press_count
);

  localparam int STAB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_TERM = STAB_W'(DEBOUNCE_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  logic s;

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (d_raw),
    .q_sync  (s)
  );

  // --------------------------------------------------------------------------
  // Debounce FSM state and registered outputs
  // --------------------------------------------------------------------------
  dbnc_state_e      state_q,       state_d;
  logic [STAB_W-1:0] stab_cnt_q,   stab_cnt_d;
  logic             d_clean_q,     d_clean_d;
  logic             rise_q,        rise_d;
  logic             fall_q,        fall_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= STABLE_LOW;
      stab_cnt_q    <= '0;
      d_clean_q     <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stab_cnt_q    <= stab_cnt_d;
      d_clean_q     <= d_clean_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      press_count_q <= press_count_d;
    end
  end

  always_comb begin
    // Hold everything by default; strobes fall back to 0 every cycle.
    state_d       = state_q;
    stab_cnt_d    = stab_cnt_q;
    d_clean_d     = d_clean_q;
    rise_d        = 1'b0;
    fall_d        = 1'b0;
    press_count_d = press_count_q;

    unique case (state_q)
      STABLE_LOW: begin
        stab_cnt_d = '0;
        if (s) begin
          state_d = PEND_HIGH;
        end
      end

      PEND_HIGH: begin
        if (!s) begin
          // Bounce: discard progress, level unchanged.
          state_d    = STABLE_LOW;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_TERM) begin
          state_d       = STABLE_HIGH;
          stab_cnt_d    = '0;
          d_clean_d     = 1'b1;
          rise_d        = 1'b1;
          press_count_d = press_count_q + CNT_W'(1);
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end

      STABLE_HIGH: begin
        stab_cnt_d = '0;
        if (!s) begin
          state_d = PEND_LOW;
        end
      end

      PEND_LOW: begin
        if (s) begin
          state_d    = STABLE_HIGH;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_TERM) begin
          state_d    = STABLE_LOW;
          stab_cnt_d = '0;
          d_clean_d  = 1'b0;
          fall_d     = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end

      default: begin
        state_d    = STABLE_LOW;
        stab_cnt_d = '0;
      end
    endcase
  end

  assign d_clean     = d_clean_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign press_count = press_count_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_debounce
//  Purpose  : Directed self-checking bench for switch_debounce
//             (DEBOUNCE_CYCLES=4, CNT_W=4).
//             Inputs are applied 1 time unit after a rising edge; call that
//             edge 0. A level held from then on is taken by the first sync
//             flop at edge 1, reaches s at edge 2, enters PEND at edge 3,
//             counts at edges 4..6 and commits at edge 7.
//  Revision : 1.0  initial release
// ============================================================================
module tb_switch_debounce;
  import debounce_pkg::*;

  localparam int DC = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          d_raw = 1'b0;
  logic          d_clean;
  logic          rise;
  logic          fall;
  logic [CW-1:0] press_count;

  int n_checks = 0;
  int n_errors = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int rise_base;
  int fall_base;

  switch_debounce #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .d_raw       (d_raw),
    .d_clean     (d_clean),
    .rise        (rise),
    .fall        (fall),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Strobe bookkeeping and mutual exclusion, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      rise_cnt += int'(rise);
      fall_cnt += int'(fall);
    end
    check_eq("rise_fall_excl", 32'(rise & fall), 32'd0);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    d_raw = 1'b0;
    step(3);
    rst = 1'b0;
  endtask

  // Hold d_raw at lvl from edge 0; expect a commit exactly at edge 7.
  task automatic expect_commit(input string tag, input logic lvl,
                               input int exp_press);
    d_raw = lvl;
    step(6);
    check_eq({tag, "_pre_level"}, 32'(d_clean), 32'(!lvl));
    check_eq({tag, "_pre_strobe"}, 32'(lvl ? rise : fall), 32'd0);
    step(1);
    check_eq({tag, "_level"}, 32'(d_clean), 32'(lvl));
    check_eq({tag, "_strobe"}, 32'(lvl ? rise : fall), 32'd1);
    check_eq({tag, "_press"}, 32'(press_count), 32'(exp_press));
    step(1);
    check_eq({tag, "_strobe_end"}, 32'(lvl ? rise : fall), 32'd0);
  endtask

  initial begin
    // ---------------- Reset with d_raw held high ----------------
    rst   = 1'b1;
    d_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq("rst_d_clean", 32'(d_clean), 32'd0);
      check_eq("rst_rise", 32'(rise), 32'd0);
      check_eq("rst_fall", 32'(fall), 32'd0);
      check_eq("rst_press", 32'(press_count), 32'd0);
    end
    check_eq("rst_state", 32'(dut.state_q), 32'(STABLE_LOW));
    rst = 1'b0;
    expect_commit("rst_release", 1'b1, 1);
    expect_commit("rst_fall", 1'b0, 1);

    // ---------------- Clean press and release ----------------
    do_reset();
    rise_base = rise_cnt;
    fall_base = fall_cnt;
    expect_commit("press", 1'b1, 1);
    step(20);
    check_eq("press_hold", 32'(d_clean), 32'd1);
    expect_commit("release", 1'b0, 1);
    check_eq("press_rises", 32'(rise_cnt - rise_base), 32'd1);
    check_eq("press_falls", 32'(fall_cnt - fall_base), 32'd1);

    // ---------------- Bounce rejection ----------------
    do_reset();
    rise_base = rise_cnt;
    for (int i = 0; i < 4; i++) begin
      d_raw = (i % 2 == 0);
      step(2);
      check_eq("bounce_level", 32'(d_clean), 32'd0);
    end
    expect_commit("bounce_settle", 1'b1, 1);
    step(10);
    check_eq("bounce_rises", 32'(rise_cnt - rise_base), 32'd1);

    // ---------------- Short glitch ----------------
    do_reset();
    rise_base = rise_cnt;
    d_raw = 1'b1;
    step(3);
    d_raw = 1'b0;
    step(10);
    check_eq("glitch_level", 32'(d_clean), 32'd0);
    check_eq("glitch_rises", 32'(rise_cnt - rise_base), 32'd0);
    check_eq("glitch_state", 32'(dut.state_q), 32'(STABLE_LOW));
    check_eq("glitch_press", 32'(press_count), 32'd0);

    // ---------------- Press counter wrap ----------------
    do_reset();
    rise_base = rise_cnt;
    for (int i = 1; i <= 16; i++) begin
      d_raw = 1'b1;
      step(8);
      if (i == 15) check_eq("wrap_15", 32'(press_count), 32'd15);
      if (i == 16) check_eq("wrap_0", 32'(press_count), 32'd0);
      d_raw = 1'b0;
      step(8);
    end
    check_eq("wrap_rises", 32'(rise_cnt - rise_base), 32'd16);

    // ---------------- Reset mid-debounce ----------------
    do_reset();
    rise_base = rise_cnt;
    d_raw = 1'b1;
    step(5);
    check_eq("mid_state", 32'(dut.state_q), 32'(PEND_HIGH));
    check_eq("mid_cnt", 32'(dut.stab_cnt_q), 32'd2);
    rst = 1'b1;
    step(1);
    check_eq("mid_rst_state", 32'(dut.state_q), 32'(STABLE_LOW));
    check_eq("mid_rst_level", 32'(d_clean), 32'd0);
    check_eq("mid_rst_rise", 32'(rise), 32'd0);
    rst = 1'b0;
    expect_commit("mid_resume", 1'b1, 1);
    check_eq("mid_rises", 32'(rise_cnt - rise_base), 32'd1);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
